multicycle_controller: RTL and testbench

Sequencing control unit for the multi-cycle RV32I datapath (program-counter register, instruction/data register, register file, extend unit, ALU and result muxes). It decodes the latched instruction fields and drives one set of datapath enables and mux selects per cycle, using a Moore main FSM plus a combinational ALU decoder. It supports lw, sw, R-type, I-type ALU, beq and jal. It adds a memory-ready stall and an illegal-opcode halt.

---
 rtl/riscv_ctrl_pkg.sv | 72 +++++++
 rtl/multicycle_controller_aludec.sv | 31 +++
 rtl/multicycle_controller.sv | 141 ++++++++++++++
 tb/tb_multicycle_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM
// states, ALU operation codes and the datapath mux-select encodings.
package riscv_ctrl_pkg;

  // Supported opcodes (Instr[6:0])
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Main FSM states
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_HALT
  } state_t;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp from the main FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_DECODE = 2'b10;

  // ImmSrc encodings
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format implied by the opcode; R-type and unknown ops fall back to I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_of = IMM_S;
      OP_BEQ:  imm_src_of = IMM_B;
      OP_JAL:  imm_src_of = IMM_J;
      default: imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// Combinational ALU decoder: turns the FSM's ALUOp plus instruction fields
// into the ALU operation code.
module aludec
  import riscv_ctrl_pkg::*;
(
  input  logic       op_b5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  // Forced add/sub from the FSM, otherwise decode funct3 (unsupported funct3 -> add)
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_DECODE: begin
        case (funct3)
          3'b000:  ALUControl = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: Moore main FSM with memory-ready stalls and
// an illegal-opcode halt, plus ALU and immediate-format decoders.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       halted
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  // State register; reset drops straight back to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; FETCH/MEMREAD/MEMWRITE hold until memory is ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_HALT;
        endcase
      end
      // op[5] separates sw from lw
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode; every select defaults to 00 so nothing floats to X
  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_DECODE;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_DECODE;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        ALUSrcA      = SRCA_RS1;
        alu_op       = ALUOP_SUB;
        pc_write_raw = Zero;
      end
      S_JAL: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so nothing can write while reset is held low
  assign PCWrite  = pc_write_raw  & reset;
  assign MemWrite = mem_write_raw & reset;
  assign IRWrite  = ir_write_raw  & reset;
  assign RegWrite = reg_write_raw & reset;
  assign halted   = (state_q == S_HALT) & reset;
  assign ImmSrc   = imm_src_of(op);

  aludec u_aludec (
    .op_b5     (op[5]),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .ALUOp     (alu_op),
    .ALUControl(ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for the multi-cycle controller. Each row is one clock
// cycle: the inputs for that cycle and the full expected output word
// {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,ALUControl,halted}.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        mr;
    logic [16:0] exp;
    logic [63:0] tag;
  } vec_t;

  vec_t vecs[$];

  // Hand-computed per-state output words (ImmSrc and ALUControl fields zero here)
  localparam logic [16:0] E_FETCH  = 17'b1_0_0_1_10_00_10_00_0_000_0;
  localparam logic [16:0] E_STALL  = 17'b0_0_0_0_10_00_10_00_0_000_0;
  localparam logic [16:0] E_DECODE = 17'b0_0_0_0_00_01_01_00_0_000_0;
  localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_00_10_01_00_0_000_0;
  localparam logic [16:0] E_MEMRD  = 17'b0_1_0_0_00_00_00_00_0_000_0;
  localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_01_00_00_00_1_000_0;
  localparam logic [16:0] E_MEMWR  = 17'b0_1_1_0_00_00_00_00_0_000_0;
  localparam logic [16:0] E_EXR    = 17'b0_0_0_0_00_10_00_00_0_000_0;
  localparam logic [16:0] E_EXI    = 17'b0_0_0_0_00_10_01_00_0_000_0;
  localparam logic [16:0] E_ALUWB  = 17'b0_0_0_0_00_00_00_00_1_000_0;
  localparam logic [16:0] E_BEQT   = 17'b1_0_0_0_00_10_00_10_0_001_0;
  localparam logic [16:0] E_BEQN   = 17'b0_0_0_0_00_10_00_10_0_001_0;
  localparam logic [16:0] E_JAL    = 17'b1_0_0_0_00_01_10_11_0_000_0;
  localparam logic [16:0] E_HALT   = 17'b0_0_0_0_00_00_00_00_0_000_1;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .RegWrite  (RegWrite),
    .ALUControl(ALUControl),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] im(input logic [16:0] e, input logic [1:0] imm);
    return e | {10'b0, imm, 5'b0};
  endfunction

  function automatic logic [16:0] al(input logic [16:0] e, input logic [2:0] alu);
    return e | {13'b0, alu, 1'b0};
  endfunction

  task automatic push(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic mr, input logic [16:0] e,
                      input logic [63:0] tag);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.exp = e; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic chk(input logic [63:0] tag, input int idx, input logic [16:0] exp);
    logic [16:0] got;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, halted};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %0s #%0d got=%b expected=%b", tag, idx, got, exp);
    end else begin
      $display("ok   %0s #%0d out=%b", tag, idx, got);
    end
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic mr);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = mr;
  endtask

  initial begin
    // R-type sub: FETCH, DECODE, EXECUTER(sub), ALUWB
    push(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1, E_FETCH, "r_fetch");
    push(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1, E_DECODE, "r_dec");
    push(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1, al(E_EXR, 3'b001), "r_sub");
    push(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1, E_ALUWB, "r_wb");
    // addi with funct7b5=1 (op[5]=0 so still add), one FETCH stall
    push(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, E_STALL, "i_stall");
    push(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1, E_FETCH, "i_fetch");
    push(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1, E_DECODE, "i_dec");
    push(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1, E_EXI, "i_addi");
    push(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1, E_ALUWB, "i_wb");
    // R-type and / slt, I-type ori, R-type unsupported funct3 -> add
    push(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1, E_FETCH, "and_f");
    push(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1, E_DECODE, "and_d");
    push(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1, al(E_EXR, 3'b010), "and_x");
    push(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1, E_ALUWB, "and_wb");
    push(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b1, E_FETCH, "slt_f");
    push(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b1, E_DECODE, "slt_d");
    push(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b1, al(E_EXR, 3'b101), "slt_x");
    push(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b1, E_ALUWB, "slt_wb");
    push(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b1, E_FETCH, "ori_f");
    push(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b1, E_DECODE, "ori_d");
    push(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b1, al(E_EXI, 3'b011), "ori_x");
    push(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b1, E_ALUWB, "ori_wb");
    push(7'b0110011, 3'b001, 1'b1, 1'b0, 1'b1, E_FETCH, "f1_f");
    push(7'b0110011, 3'b001, 1'b1, 1'b0, 1'b1, E_DECODE, "f1_d");
    push(7'b0110011, 3'b001, 1'b1, 1'b0, 1'b1, E_EXR, "f1_x");
    push(7'b0110011, 3'b001, 1'b1, 1'b0, 1'b1, E_ALUWB, "f1_wb");
    // lw with two MEMREAD stalls: 7 cycles
    push(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1, E_FETCH, "lw_f");
    push(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1, E_DECODE, "lw_d");
    push(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1, E_MEMADR, "lw_adr");
    push(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, E_MEMRD, "lw_rd0");
    push(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, E_MEMRD, "lw_rd1");
    push(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1, E_MEMRD, "lw_rd2");
    push(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1, E_MEMWB, "lw_wb");
    // sw, no stall: MemWrite only in cycle 4, ImmSrc=S
    push(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, im(E_FETCH, 2'b01), "sw_f");
    push(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, im(E_DECODE, 2'b01), "sw_d");
    push(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, im(E_MEMADR, 2'b01), "sw_adr");
    push(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, im(E_MEMWR, 2'b01), "sw_wr");
    // sw with one MEMWRITE stall: MemWrite held both cycles
    push(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, im(E_FETCH, 2'b01), "sws_f");
    push(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, im(E_DECODE, 2'b01), "sws_d");
    push(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, im(E_MEMADR, 2'b01), "sws_adr");
    push(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, im(E_MEMWR, 2'b01), "sws_wr0");
    push(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, im(E_MEMWR, 2'b01), "sws_wr1");
    // beq taken then not taken
    push(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1, im(E_FETCH, 2'b10), "beqt_f");
    push(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1, im(E_DECODE, 2'b10), "beqt_d");
    push(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1, E_BEQT, "beqt_x");
    push(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1, im(E_FETCH, 2'b10), "beqn_f");
    push(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1, im(E_DECODE, 2'b10), "beqn_d");
    push(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1, E_BEQN, "beqn_x");
    // jal with Zero high (must not matter outside BEQ)
    push(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b1, im(E_FETCH, 2'b11), "jal_f");
    push(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b1, im(E_DECODE, 2'b11), "jal_d");
    push(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b1, E_JAL, "jal_x");
    push(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b1, im(E_ALUWB, 2'b11), "jal_wb");
    // illegal op -> HALT for 10 cycles regardless of mem_ready/Zero
    push(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, E_FETCH, "ill_f");
    push(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, E_DECODE, "ill_d");
    for (int i = 0; i < 10; i++)
      push(7'b1111111, 3'b000, 1'b0, i[0], i[1], E_HALT, "halt");

    // Reset held low with mem_ready high: FETCH selects, all strobes off
    reset = 1'b0;
    drive(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    #2 chk("reset", 0, E_STALL);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Table: one row per cycle, sampled mid-low-phase
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].mr);
      #1 chk(vecs[i].tag, i, vecs[i].exp);
      @(negedge clk);
    end

    // Still in HALT: asynchronous reset mid-cycle returns to FETCH
    drive(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
    #1 chk("halt_pre", 0, E_HALT);
    reset = 1'b0;
    #1 chk("halt_rst", 0, E_STALL);
    @(negedge clk);
    reset = 1'b1;

    // R-type abandoned by reset right after entering ALUWB
    drive(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    #1 chk("ab_f", 0, E_FETCH);
    @(negedge clk);
    #1 chk("ab_d", 0, E_DECODE);
    @(negedge clk);
    #1 chk("ab_x", 0, al(E_EXR, 3'b001));
    @(posedge clk);
    #1 chk("ab_wb", 0, E_ALUWB);
    reset = 1'b0;
    #1 chk("ab_rst", 0, E_STALL);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1 chk("ab_stall", 0, E_STALL);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("ab_fetch", 0, E_FETCH);
    @(negedge clk);
    #1 chk("ab_dec", 0, E_DECODE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
